// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared encodings for the modulo-N up/down counter family.
//   MODE_WRAP / MODE_SAT : behaviour when the count sits on its terminal value
//   DIR_DOWN  / DIR_UP   : counting direction
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_next_logic.sv
// ---------------------------------------------------------------------------
// counter_next_logic
// Purely combinational next-count computation for a modulo-MODULUS counter.
// Ports:
//   count       in  WIDTH  current registered count
//   dir         in  1      1 = up, 0 = down
//   mode        in  1      0 = wrap at terminal, 1 = saturate at terminal
//   x           in  1      count enable
//   next_count  out WIDTH  count to register if counting is selected
//   at_terminal out 1      count equals terminal value for the current dir
//   wrap_event  out 1      a wrap happens if this next_count is taken
// ---------------------------------------------------------------------------
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             mode,
  input  logic             x,
  output logic [WIDTH-1:0] next_count,
  output logic             at_terminal,
  output logic             wrap_event
);

  // One guard bit so MODULUS-1+1 never silently folds back at 2**WIDTH.
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ZERO_W = (WIDTH+1)'(0);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

  logic [WIDTH:0] ext_s;
  logic [WIDTH:0] next_ext_s;

  assign ext_s      = {1'b0, count};
  assign next_count = WIDTH'(next_ext_s);

  // Terminal detection and next-count selection (wrap, saturate or step).
  always_comb begin
    next_ext_s  = ext_s;
    wrap_event  = 1'b0;
    at_terminal = 1'b0;

    if (dir == DIR_UP) begin
      at_terminal = (ext_s == MAX_W);
    end else begin
      at_terminal = (ext_s == ZERO_W);
    end

    if (!x) begin
      next_ext_s = ext_s;
    end else if (at_terminal) begin
      case (mode)
        MODE_WRAP: begin
          next_ext_s = (dir == DIR_UP) ? ZERO_W : MAX_W;
          wrap_event = 1'b1;
        end
        MODE_SAT: begin
          next_ext_s = ext_s;
        end
        default: begin
          next_ext_s = ext_s;
        end
      endcase
    end else if (dir == DIR_UP) begin
      next_ext_s = ext_s + ONE_W;
    end else begin
      next_ext_s = ext_s - ONE_W;
    end
  end

endmodule : counter_next_logic

// File: rtl/mod_n_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_n_updown_counter
// Modulo-MODULUS up/down counter with enable, clamped parallel load,
// wrap/saturate mode, Mealy terminal-count flag and sticky overflow.
// Edge priority: reset > load > count > hold.
// Ports:
//   clk      in  1      rising-edge clock
//   reset    in  1      synchronous active-high reset
//   x        in  1      count enable
//   dir      in  1      1 = up, 0 = down
//   mode     in  1      0 = wrap, 1 = saturate
//   load     in  1      synchronous load strobe
//   load_val in  WIDTH  load value (clamped to MODULUS-1)
//   out      out WIDTH  registered count
//   z        out 1      combinational terminal-count flag
//   ovf      out 1      sticky wrap flag, cleared by reset or load
// ---------------------------------------------------------------------------
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             ovf
);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_r;
  logic             ovf_r;
  logic [WIDTH-1:0] next_count_s;
  logic             at_terminal_s;
  logic             wrap_event_s;
  logic [WIDTH-1:0] load_clamped_s;

  counter_next_logic #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count       (count_r),
    .dir         (dir),
    .mode        (mode),
    .x           (x),
    .next_count  (next_count_s),
    .at_terminal (at_terminal_s),
    .wrap_event  (wrap_event_s)
  );

  // Out-of-range load values saturate to the top of the count range.
  always_comb begin
    load_clamped_s = load_val;
    if ({1'b0, load_val} > MAX_W) begin
      load_clamped_s = MAX_N;
    end else begin
      load_clamped_s = load_val;
    end
  end

  // Count and overflow registers with reset > load > count > hold priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
    end else if (load) begin
      count_r <= load_clamped_s;
      ovf_r   <= 1'b0;
    end else if (x) begin
      count_r <= next_count_s;
      ovf_r   <= ovf_r | wrap_event_s;
    end else begin
      count_r <= count_r;
      ovf_r   <= ovf_r;
    end
  end

  assign out = count_r;
  assign ovf = ovf_r;
  // Mealy flag: high in the cycle whose edge will wrap or saturate.
  assign z   = x & ~reset & ~load & at_terminal_s;

endmodule : mod_n_updown_counter

// File: tb/tb_mod_n_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_n_updown_counter
// Drives a default (WIDTH=2, MODULUS=4) and a (WIDTH=3, MODULUS=6) instance
// with shared control inputs; both are checked against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_mod_n_updown_counter;

  logic       clk1 = 1'b0;
  logic       reset, x, dir, mode, load;
  logic [1:0] lv_a;
  logic [2:0] lv_b;
  logic [1:0] out_a;
  logic [2:0] out_b;
  logic       z_a, z_b, ovf_a, ovf_b;

  int compared   = 0;
  int mismatched = 0;

  int cnt_a = 0, cnt_b = 0;
  bit mo_a  = 1'b0, mo_b = 1'b0;

  always #5 clk1 = ~clk1;

  mod_n_updown_counter #(.WIDTH(2), .MODULUS(4)) dut_a (
    .clk(clk1), .reset(reset), .x(x), .dir(dir), .mode(mode),
    .load(load), .load_val(lv_a), .out(out_a), .z(z_a), .ovf(ovf_a)
  );

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(6)) dut_b (
    .clk(clk1), .reset(reset), .x(x), .dir(dir), .mode(mode),
    .load(load), .load_val(lv_b), .out(out_b), .z(z_b), .ovf(ovf_b)
  );

  function automatic bit model_z(input int m, input bit r, input bit xx,
                                 input bit d, input bit l, input int c);
    return xx && !r && !l && (c == (d ? m - 1 : 0));
  endfunction

  function automatic void model_step(input int m, input bit r, input bit xx,
                                     input bit d, input bit md, input bit l,
                                     input int lvv, inout int c, inout bit o);
    if (r) begin
      c = 0; o = 1'b0;
    end else if (l) begin
      c = (lvv > m - 1) ? m - 1 : lvv; o = 1'b0;
    end else if (xx) begin
      if (d && c == m - 1) begin
        if (!md) begin c = 0; o = 1'b1; end
      end else if (!d && c == 0) begin
        if (!md) begin c = m - 1; o = 1'b1; end
      end else begin
        c = d ? c + 1 : c - 1;
      end
    end
  endfunction

  task automatic cycle(input bit r, input bit xx, input bit d, input bit md,
                       input bit l, input int la, input int lb);
    logic [1:0] ea;
    logic [2:0] eb;
    bit eza, ezb;
    @(negedge clk1);
    reset = r; x = xx; dir = d; mode = md; load = l;
    lv_a = 2'(la); lv_b = 3'(lb);
    #1;
    eza = model_z(4, r, xx, d, l, cnt_a);
    ezb = model_z(6, r, xx, d, l, cnt_b);
    compared++;
    assert (z_a === eza) else begin
      mismatched++; $error("FAIL z_a observed=%b expected=%b", z_a, eza);
    end
    compared++;
    assert (z_b === ezb) else begin
      mismatched++; $error("FAIL z_b observed=%b expected=%b", z_b, ezb);
    end
    @(posedge clk1);
    model_step(4, r, xx, d, md, l, la, cnt_a, mo_a);
    model_step(6, r, xx, d, md, l, lb, cnt_b, mo_b);
    #1;
    ea = 2'(cnt_a);
    eb = 3'(cnt_b);
    compared++;
    assert (out_a === ea) else begin
      mismatched++; $error("FAIL out_a observed=%0d expected=%0d", out_a, ea);
    end
    compared++;
    assert (out_b === eb) else begin
      mismatched++; $error("FAIL out_b observed=%0d expected=%0d", out_b, eb);
    end
    compared++;
    assert (ovf_a === mo_a) else begin
      mismatched++; $error("FAIL ovf_a observed=%b expected=%b", ovf_a, mo_a);
    end
    compared++;
    assert (ovf_b === mo_b) else begin
      mismatched++; $error("FAIL ovf_b observed=%b expected=%b", ovf_b, mo_b);
    end
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; dir = 1'b1; mode = 1'b0; load = 1'b0;
    lv_a = 2'd0; lv_b = 3'd0;

    // Reset for two edges, with x high so z must still be suppressed.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Up count with x toggling every other clock, wrap mode.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'(i % 2), 1'b1, 1'b0, 1'b0, 0, 0);

    // Continuous up count through the MODULUS=6 wrap.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    // Saturate up, then reverse and saturate at zero.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++)  cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

    // Wrap to set ovf, then clamped load clears it; load beats x.
    for (int i = 0; i < 2; i++)  cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 7);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    // At count 3, reset and load together: reset wins; resume from zero.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    // Down-wrap from a loaded zero.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // Randomised traffic over all controls.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mod_n_updown_counter

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised successor to the lab's 2-bit x-enabled counter.
- Modulo-N up/down counter with enable input x, synchronous parallel load, and a wrap/saturate mode.
- Outputs: a Mealy terminal-count flag z and a sticky overflow flag.
- Used as the common counting element for the later counter and timer exercises; the default parameters reproduce the 2-bit counter behaviour.

Parameters:
- WIDTH, 2, bit width of the count register and load value.
- MODULUS, 4, count range 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH; the build fails otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- x  input  1  count enable; one step per clk edge while high.
- dir  input  1  1 = count up, 0 = count down.
- mode  input  1  0 = wrap at the boundary, 1 = saturate at the boundary.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- out  output  WIDTH  registered count.
- z  output  1  combinational terminal-count flag (Mealy).
- ovf  output  1  sticky flag, set when a wrap occurs.

Behaviour:
- Reset:
  - Synchronous, active-high. Clock and reset are named clk and reset.
  - On a clk edge with reset=1: out=0, ovf=0.
  - z is forced to 0 while reset=1.
- Priority on each clk edge: reset > load > count > hold.
- Load:
  - out <= load_val if load_val <= MODULUS-1, otherwise out <= MODULUS-1 (clamped).
  - Load clears ovf.
  - x is ignored on a load cycle.
- Count when x=1 and load=0:
  - Up: out+1. Down: out-1.
  - Arithmetic is carried in WIDTH+1 bits internally; no silent 2**WIDTH wrap when MODULUS < 2**WIDTH.
- Boundaries:
  - Terminal value is MODULUS-1 when dir=1, and 0 when dir=0.
  - At terminal with x=1 and mode=0: out wraps (MODULUS-1 -> 0 going up, 0 -> MODULUS-1 going down) and ovf <= 1.
  - At terminal with x=1 and mode=1: out holds and ovf is unchanged.
- Hold: x=0 and load=0 leaves out unchanged.
- z = x & ~reset & ~load & (out == terminal(dir)).
  - Combinational: it asserts in the same cycle as the edge that wraps or saturates.
  - Asserted in both modes.
- ovf:
  - Cleared only by reset or load.
  - Stays set across any number of further wraps.
- Changing dir mid-count takes effect on the next edge; there is no extra latency.
- Reset mid-count returns to 0 on that edge regardless of load or x.
- Latency: out updates one edge after the inputs are sampled; z has zero latency.
- State: the count register and ovf are the only state; there is no hidden FSM.

Decomposition:
- Package counter_pkg holds:
  - MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - DIR_DOWN=1'b0, DIR_UP=1'b1.
- One combinational sub-module, counter_next_logic, takes out, dir, mode and x. It returns next_count, at_terminal and wrap_event.
- The top level holds the registers, load clamping, priority and the z/ovf logic.

Test Plan:
- Defaults (WIDTH=2, MODULUS=4), reset=1 for 2 edges, then x toggling every other clk, dir=1, mode=0 -> out steps 0,1,2,3,0. z=1 only in the cycle where out=3 and x=1. ovf=1 after the first wrap.
- WIDTH=3, MODULUS=6, dir=1, mode=0, x=1 continuously -> out 0,1,2,3,4,5,0. It never reaches 6 or 7; z high exactly when out=5.
- WIDTH=3, MODULUS=6, mode=1, dir=1, x=1 for 10 edges -> out saturates at 5 with z held high and ovf=0. Then dir=0 -> out 4,3,2,1,0 and holds at 0 with z=1.
- Load with load_val=7 (WIDTH=3, MODULUS=6) -> out=5 (clamped) and ovf cleared. load_val=2 with x=1 on the same edge -> out=2, no increment.
- Mid-count at out=3, assert reset and load together -> out=0, ovf=0, z=0 during reset. Counting resumes from 0 after reset drops.
- Down-wrap with defaults: load 0, dir=0, mode=0, x=1 -> out 0,3,2,1,0,3. z=1 whenever out=0, and ovf sets on the first 0 -> 3 transition.
